// File: rtl/mem_stage.sv
// mem_stage: MEM stage with MEM/WB pipeline register.
// Each load/store runs one dcache request/dhit handshake. Upstream is stalled
// through mem_busy while an access is in progress. The MEM/WB register selects
// the writeback data and holds it for the WB stage.
// Optional build macro: MEM_STAGE_STATS_EN adds the stall and completed-access
// counters stat_stall and stat_memops.
module mem_stage #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic              wen_i,
    input  logic [REG_W-1:0]  wsel_i,
    input  logic [1:0]        W_mux_i,
    input  logic [WORD_W-1:0] LUI_i,
    input  logic [WORD_W-1:0] npc_i,
    input  logic [WORD_W-1:0] dmemaddr_i,
    input  logic [WORD_W-1:0] dmemstore_i,
    input  logic              d_ren_i,
    input  logic              d_wen_i,
    input  logic              halt_i,
    input  logic [WORD_W-1:0] imemload_i,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mem_busy,
    output logic              wb_valid,
    output logic              wb_wen,
    output logic [REG_W-1:0]  wb_wsel,
    output logic [WORD_W-1:0] wb_wdat,
    output logic              wb_halt,
    output logic [WORD_W-1:0] wb_imemload
`ifdef MEM_STAGE_STATS_EN
    ,
    output logic [31:0]       stat_stall,
    output logic [31:0]       stat_memops
`endif
);

    typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t state, state_next;

    // Copy of the instruction held for the duration of a dcache access
    logic              lat_wen;
    logic [REG_W-1:0]  lat_wsel;
    logic [1:0]        lat_wmux;
    logic [WORD_W-1:0] lat_lui;
    logic [WORD_W-1:0] lat_npc;
    logic [WORD_W-1:0] lat_addr;
    logic [WORD_W-1:0] lat_store;
    logic              lat_ren;
    logic              lat_dwen;
    logic              lat_halt;
    logic [WORD_W-1:0] lat_imem;

    logic              live;
    logic              mem_op;
    logic              capture;
    logic              wb_load;
    logic              src_wen;
    logic [REG_W-1:0]  src_wsel;
    logic [WORD_W-1:0] src_wdat;
    logic              src_halt;
    logic [WORD_W-1:0] src_imem;

    // Writeback mux. A store (including ren+wen together) never returns load data.
    function automatic logic [WORD_W-1:0] sel_wdat(
        input logic [1:0]        wmux,
        input logic              ren,
        input logic              dwen,
        input logic [WORD_W-1:0] alu,
        input logic [WORD_W-1:0] load,
        input logic [WORD_W-1:0] lui,
        input logic [WORD_W-1:0] npc
    );
        logic [WORD_W-1:0] r;
        case (wmux)
            2'd0:    r = alu;
            2'd1:    r = (ren && !dwen) ? load : WORD_W'(0);
            2'd2:    r = lui;
            default: r = npc;
        endcase
        return r;
    endfunction

    assign live   = valid_i & ~flush_i & ~wb_halt;
    assign mem_op = d_ren_i | d_wen_i;

    // Request outputs decode the registered state and latch, so reset clears them at once
    assign dmemREN   = (state == ACCESS) & lat_ren & ~lat_dwen;
    assign dmemWEN   = (state == ACCESS) & lat_dwen;
    assign dmemaddr  = lat_addr;
    assign dmemstore = lat_store;

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_next;
    end

    // Next state, stall, and MEM/WB load source
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        wb_load    = 1'b0;
        mem_busy   = 1'b0;
        src_wen    = wen_i;
        src_wsel   = wsel_i;
        src_wdat   = sel_wdat(W_mux_i, d_ren_i, d_wen_i, dmemaddr_i, dmemload, LUI_i, npc_i);
        src_halt   = halt_i;
        src_imem   = imemload_i;
        case (state)
            IDLE: begin
                if (live && mem_op) begin
                    capture    = 1'b1;
                    mem_busy   = 1'b1;
                    state_next = ACCESS;
                end else if (live) begin
                    wb_load = 1'b1;
                end
            end
            ACCESS: begin
                src_wen  = lat_wen;
                src_wsel = lat_wsel;
                src_wdat = sel_wdat(lat_wmux, lat_ren, lat_dwen, lat_addr, dmemload, lat_lui, lat_npc);
                src_halt = lat_halt;
                src_imem = lat_imem;
                if (dhit) begin
                    wb_load    = 1'b1;
                    state_next = IDLE;
                end else begin
                    mem_busy = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture the memory instruction when its access starts
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            lat_wen   <= 1'b0;
            lat_wsel  <= '0;
            lat_wmux  <= 2'd0;
            lat_lui   <= '0;
            lat_npc   <= '0;
            lat_addr  <= '0;
            lat_store <= '0;
            lat_ren   <= 1'b0;
            lat_dwen  <= 1'b0;
            lat_halt  <= 1'b0;
            lat_imem  <= '0;
        end else if (capture) begin
            lat_wen   <= wen_i;
            lat_wsel  <= wsel_i;
            lat_wmux  <= W_mux_i;
            lat_lui   <= LUI_i;
            lat_npc   <= npc_i;
            lat_addr  <= dmemaddr_i;
            lat_store <= dmemstore_i;
            lat_ren   <= d_ren_i;
            lat_dwen  <= d_wen_i;
            lat_halt  <= halt_i;
            lat_imem  <= imemload_i;
        end
    end

    // MEM/WB register: retire an instruction or insert a bubble
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wb_valid    <= 1'b0;
            wb_wen      <= 1'b0;
            wb_wsel     <= '0;
            wb_wdat     <= '0;
            wb_halt     <= 1'b0;
            wb_imemload <= '0;
        end else if (wb_load) begin
            wb_valid    <= 1'b1;
            wb_wen      <= src_wen;
            wb_wsel     <= src_wsel;
            wb_wdat     <= src_wdat;
            wb_halt     <= wb_halt | src_halt;
            wb_imemload <= src_imem;
        end else begin
            wb_valid <= 1'b0;
            wb_wen   <= 1'b0;
        end
    end

`ifdef MEM_STAGE_STATS_EN
    // Stall and completed-access counters, frozen after halt
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_stall  <= 32'd0;
            stat_memops <= 32'd0;
        end else if (!wb_halt) begin
            if (mem_busy)
                stat_stall <= stat_stall + 32'd1;
            if (state == ACCESS && dhit)
                stat_memops <= stat_memops + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vectors, with a scoreboard queue that holds the
// expected retirements and a monitor process that checks the MEM/WB outputs.
module tb_mem_stage;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        valid_i, flush_i, wen_i, d_ren_i, d_wen_i, halt_i, dhit;
    logic [4:0]  wsel_i;
    logic [1:0]  W_mux_i;
    logic [31:0] LUI_i, npc_i, dmemaddr_i, dmemstore_i, imemload_i, dmemload;
    logic        dmemREN, dmemWEN, mem_busy, wb_valid, wb_wen, wb_halt;
    logic [31:0] dmemaddr, dmemstore, wb_wdat, wb_imemload;
    logic [4:0]  wb_wsel;
`ifdef MEM_STAGE_STATS_EN
    logic [31:0] stat_stall, stat_memops;
`endif

    typedef struct packed {
        logic [4:0]  wsel;
        logic        wen;
        logic [31:0] wdat;
        logic        halt;
        logic [31:0] imem;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .CLK(CLK), .nRST(nRST), .valid_i(valid_i), .flush_i(flush_i),
        .wen_i(wen_i), .wsel_i(wsel_i), .W_mux_i(W_mux_i), .LUI_i(LUI_i),
        .npc_i(npc_i), .dmemaddr_i(dmemaddr_i), .dmemstore_i(dmemstore_i),
        .d_ren_i(d_ren_i), .d_wen_i(d_wen_i), .halt_i(halt_i),
        .imemload_i(imemload_i), .dhit(dhit), .dmemload(dmemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .mem_busy(mem_busy), .wb_valid(wb_valid),
        .wb_wen(wb_wen), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat),
        .wb_halt(wb_halt), .wb_imemload(wb_imemload)
`ifdef MEM_STAGE_STATS_EN
        , .stat_stall(stat_stall), .stat_memops(stat_memops)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        valid_i = 0; flush_i = 0; wen_i = 0; wsel_i = 0; W_mux_i = 0;
        LUI_i = 0; npc_i = 0; dmemaddr_i = 0; dmemstore_i = 0;
        d_ren_i = 0; d_wen_i = 0; halt_i = 0; imemload_i = 0;
        dhit = 0; dmemload = 0;
    endtask

    task automatic drive(input logic wen, input logic [4:0] wsel, input logic [1:0] wmux,
                         input logic [31:0] lui, input logic [31:0] npc, input logic [31:0] addr,
                         input logic [31:0] store, input logic ren, input logic dwen,
                         input logic halt, input logic [31:0] imem);
        valid_i = 1; flush_i = 0; wen_i = wen; wsel_i = wsel; W_mux_i = wmux;
        LUI_i = lui; npc_i = npc; dmemaddr_i = addr; dmemstore_i = store;
        d_ren_i = ren; d_wen_i = dwen; halt_i = halt; imemload_i = imem;
    endtask

    task automatic push(input logic [4:0] wsel, input logic wen, input logic [31:0] wdat,
                        input logic halt, input logic [31:0] imem);
        wb_exp_t e;
        e.wsel = wsel; e.wen = wen; e.wdat = wdat; e.halt = halt; e.imem = imem;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every retirement is matched against the head of the scoreboard
    always @(negedge CLK) begin
        if (nRST === 1'b1) begin
            if (!wb_valid) begin
                check("bubble_wen_gated", 32'(wb_wen), 32'd0);
            end else if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_retire: got wsel=%0d wdat=0x%08h expected no retirement", wb_wsel, wb_wdat);
            end else begin
                wb_exp_t e;
                e = exp_q.pop_front();
                check("wb_wsel", 32'(wb_wsel), 32'(e.wsel));
                check("wb_wen", 32'(wb_wen), 32'(e.wen));
                check("wb_wdat", wb_wdat, e.wdat);
                check("wb_halt", 32'(wb_halt), 32'(e.halt));
                check("wb_imemload", wb_imemload, e.imem);
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_n, ren_n, wen_n;
        nRST = 0;
        clear_inputs();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_halt", 32'(wb_halt), 32'd0);
        check("rst_wb_wdat", wb_wdat, 32'd0);
        check("rst_dmemREN", 32'(dmemREN), 32'd0);
        check("rst_dmemWEN", 32'(dmemWEN), 32'd0);
        check("rst_mem_busy", 32'(mem_busy), 32'd0);
        step();
        nRST = 1;
        step();

        // ALU op: retires after one edge without stalling
        drive(1, 5'd3, 2'd0, 32'h0, 32'h0, 32'h10, 32'h0, 0, 0, 0, 32'hA1);
        @(negedge CLK);
        check("add_busy", 32'(mem_busy), 32'd0);
        push(5'd3, 1'b1, 32'h10, 1'b0, 32'hA1);
        step();
        clear_inputs();
        @(negedge CLK);
        check("add_latency_valid", 32'(wb_valid), 32'd1);
        step();

        // Load with three miss cycles before dhit
        drive(1, 5'd5, 2'd1, 32'h0, 32'h0, 32'h40, 32'h0, 1, 0, 0, 32'hA2);
        push(5'd5, 1'b1, 32'hDEADBEEF, 1'b0, 32'hA2);
        busy_n = 0; ren_n = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin dhit = 1; dmemload = 32'hDEADBEEF; end
            @(negedge CLK);
            if (mem_busy) busy_n++;
            if (dmemREN) ren_n++;
            if (i == 2) check("load_addr", dmemaddr, 32'h40);
            if (i == 4) check("load_no_wen", 32'(dmemWEN), 32'd0);
            step();
            dhit = 0;
            if (i == 4) clear_inputs();
        end
        check("load_busy_cycles", 32'(busy_n), 32'd4);
        check("load_ren_cycles", 32'(ren_n), 32'd4);

        // Store with a flush pulse during the access: completes and retires
        drive(0, 5'd7, 2'd0, 32'h0, 32'h0, 32'h80, 32'h1234, 0, 1, 0, 32'hA3);
        push(5'd7, 1'b0, 32'h80, 1'b0, 32'hA3);
        wen_n = 0;
        for (int i = 0; i < 7; i++) begin
            if (i == 2) flush_i = 1;
            if (i == 3) dhit = 1;
            @(negedge CLK);
            if (dmemWEN) wen_n++;
            if (i == 2) check("store_addr_flush", dmemaddr, 32'h80);
            if (i == 3) check("store_data", dmemstore, 32'h1234);
            step();
            flush_i = 0;
            dhit = 0;
            if (i == 3) clear_inputs();
        end
        check("store_wen_cycles", 32'(wen_n), 32'd3);

        // ren and wen together: a store, LOAD select yields 0
        drive(1, 5'd9, 2'd1, 32'h0, 32'h0, 32'hC0, 32'h55, 1, 1, 0, 32'hA4);
        push(5'd9, 1'b1, 32'h0, 1'b0, 32'hA4);
        ren_n = 0; wen_n = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin dhit = 1; dmemload = 32'hFFFFFFFF; end
            @(negedge CLK);
            if (dmemREN) ren_n++;
            if (dmemWEN) wen_n++;
            step();
            dhit = 0;
            if (i == 1) clear_inputs();
        end
        check("both_ren_cycles", 32'(ren_n), 32'd0);
        check("both_wen_cycles", 32'(wen_n), 32'd1);

        // LUI to r0 passes through; LOAD select on a non-memory op gives 0
        drive(1, 5'd0, 2'd2, 32'hABCD0000, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'hA5);
        push(5'd0, 1'b1, 32'hABCD0000, 1'b0, 32'hA5);
        step();
        drive(1, 5'd12, 2'd1, 32'h0, 32'h0, 32'h77, 32'h0, 0, 0, 0, 32'hA6);
        push(5'd12, 1'b1, 32'h0, 1'b0, 32'hA6);
        step();
        clear_inputs();
        step();

        // Flushed load in IDLE: no request, no stall, bubble
        drive(1, 5'd4, 2'd1, 32'h0, 32'h0, 32'h40, 32'h0, 1, 0, 0, 32'hA7);
        flush_i = 1;
        @(negedge CLK);
        check("flush_busy", 32'(mem_busy), 32'd0);
        step();
        clear_inputs();
        @(negedge CLK);
        check("flush_no_ren", 32'(dmemREN), 32'd0);
        check("flush_bubble", 32'(wb_valid), 32'd0);
        step();

        // Reset during an access drops the request immediately
        drive(1, 5'd6, 2'd1, 32'h0, 32'h0, 32'h44, 32'h0, 1, 0, 0, 32'hA8);
        step();
        @(negedge CLK);
        check("rst_mid_ren_before", 32'(dmemREN), 32'd1);
        #2;
        nRST = 0;
        clear_inputs();
        #1;
        check("rst_mid_ren", 32'(dmemREN), 32'd0);
        check("rst_mid_wen", 32'(dmemWEN), 32'd0);
        check("rst_mid_busy", 32'(mem_busy), 32'd0);
`ifdef MEM_STAGE_STATS_EN
        check("rst_mid_stat_stall", stat_stall, 32'd0);
        check("rst_mid_stat_memops", stat_memops, 32'd0);
`endif
        step();
        nRST = 1;
        step();

        // JAL then halt; afterwards a load issues no request
        drive(1, 5'd31, 2'd3, 32'h0, 32'h104, 32'h0, 32'h0, 0, 0, 0, 32'hA9);
        push(5'd31, 1'b1, 32'h104, 1'b0, 32'hA9);
        step();
        drive(0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 1, 32'hAA);
        push(5'd0, 1'b0, 32'h0, 1'b1, 32'hAA);
        step();
        drive(1, 5'd2, 2'd1, 32'h0, 32'h0, 32'h48, 32'h0, 1, 0, 0, 32'hAB);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge CLK);
            check("halted_no_ren", 32'(dmemREN), 32'd0);
            check("halted_no_busy", 32'(mem_busy), 32'd0);
            check("halt_sticky", 32'(wb_halt), 32'd1);
        end
        clear_inputs();
        repeat (3) step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
